// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA counters with pixel request, 2-stage aligned sync/blank/RGB outputs and frame counter
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_req,
  output logic [9:0]  o_x,
  output logic [9:0]  o_y,
  input  logic [7:0]  i_R,
  input  logic [7:0]  i_G,
  input  logic [7:0]  i_B,
  output logic [7:0]  o_VGA_R,
  output logic [7:0]  o_VGA_G,
  output logic [7:0]  o_VGA_B,
  output logic        o_H_sync,
  output logic        o_V_sync,
  output logic        o_VGA_BLANK_N,
  output logic        o_frame_start,
  output logic [15:0] o_frame_cnt
);
  localparam logic [9:0] H_ACT = 10'(H_ACTIVE);
  localparam logic [9:0] H_SS  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SE  = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] H_END = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_ACT = 10'(V_ACTIVE);
  localparam logic [9:0] V_SS  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SE  = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] V_END = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  logic [9:0]  r_h_cnt, r_v_cnt;
  logic [1:0]  r_act, r_hs, r_vs, r_fs;
  logic [7:0]  r_r, r_g, r_b;
  logic [15:0] r_frame_cnt;
  logic        w_h_end, w_v_end, w_active, w_hs, w_vs, w_fs;
  assign w_h_end  = r_h_cnt == H_END;
  assign w_v_end  = r_v_cnt == V_END;
  assign w_active = !i_rst && r_h_cnt < H_ACT && r_v_cnt < V_ACT;
  assign w_hs     = !(r_h_cnt >= H_SS && r_h_cnt < H_SE);
  assign w_vs     = !(r_v_cnt >= V_SS && r_v_cnt < V_SE);
  assign w_fs     = w_active && r_h_cnt == '0 && r_v_cnt == '0;
  assign o_req    = w_active;
  assign o_x      = w_active ? r_h_cnt : '0;
  assign o_y      = w_active ? r_v_cnt : '0;
  always_ff @(posedge i_clk)
    if (i_rst) begin
      r_h_cnt     <= '0;
      r_v_cnt     <= '0;
      r_act       <= '0;
      r_hs        <= '1;
      r_vs        <= '1;
      r_fs        <= '0;
      r_r         <= '0;
      r_g         <= '0;
      r_b         <= '0;
      r_frame_cnt <= '0;
    end else begin
      r_h_cnt     <= w_h_end ? '0 : r_h_cnt + 10'd1;
      r_v_cnt     <= w_h_end ? (w_v_end ? '0 : r_v_cnt + 10'd1) : r_v_cnt;
      r_frame_cnt <= r_frame_cnt + {15'd0, w_h_end && w_v_end};
      r_act       <= {r_act[0], w_active};
      r_hs        <= {r_hs[0], w_hs};
      r_vs        <= {r_vs[0], w_vs};
      r_fs        <= {r_fs[0], w_fs};
      r_r         <= r_act[0] ? i_R : '0;
      r_g         <= r_act[0] ? i_G : '0;
      r_b         <= r_act[0] ? i_B : '0;
    end
  assign o_VGA_R       = r_r;
  assign o_VGA_G       = r_g;
  assign o_VGA_B       = r_b;
  assign o_H_sync      = r_hs[1];
  assign o_V_sync      = r_vs[1];
  assign o_VGA_BLANK_N = r_act[1];
  assign o_frame_start = r_fs[1];
  assign o_frame_cnt   = r_frame_cnt;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks on a default 800x525 instance and a tiny 8x4 instance
module tb_vga_timing_gen;
  logic clk = 0, rst = 1, rst_s = 1;
  logic [7:0] i_R = 0, i_G = 0, i_B = 8'hA5, s_pix = 8'h3C;
  logic req, hs, vs, bn, fs;
  logic [9:0] x, y;
  logic [7:0] vr, vg, vb;
  logic [15:0] fc;
  logic s_req, s_hs, s_vs, s_bn, s_fs;
  logic [9:0] s_x, s_y;
  logic [7:0] s_r, s_g, s_b;
  logic [15:0] s_fc;
  int total = 0, bad = 0, k = 0, ks = 0;
  logic [7:0] px = 0, py = 0;
  vga_timing_gen u_dut (
    .i_clk(clk), .i_rst(rst), .o_req(req), .o_x(x), .o_y(y),
    .i_R(i_R), .i_G(i_G), .i_B(i_B),
    .o_VGA_R(vr), .o_VGA_G(vg), .o_VGA_B(vb),
    .o_H_sync(hs), .o_V_sync(vs), .o_VGA_BLANK_N(bn),
    .o_frame_start(fs), .o_frame_cnt(fc)
  );
  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(0)
  ) u_s (
    .i_clk(clk), .i_rst(rst_s), .o_req(s_req), .o_x(s_x), .o_y(s_y),
    .i_R(s_pix), .i_G(s_pix), .i_B(s_pix),
    .o_VGA_R(s_r), .o_VGA_G(s_g), .o_VGA_B(s_b),
    .o_H_sync(s_hs), .o_V_sync(s_vs), .o_VGA_BLANK_N(s_bn),
    .o_frame_start(s_fs), .o_frame_cnt(s_fc)
  );
  always #20 clk = ~clk;
  task automatic step();
    @(negedge clk);
    k++;
    ks++;
    i_R = px;
    i_G = py;
    px = x[7:0];
    py = y[7:0];
  endtask
  task automatic test_reset();
    rst = 1;
    repeat (3) @(negedge clk);
    total++; if (req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b want=0", req); end
    total++; if (x !== 10'd0 || y !== 10'd0) begin bad++; $display("FAIL reset_xy got=%0d,%0d want=0,0", x, y); end
    total++; if (bn !== 1'b0) begin bad++; $display("FAIL reset_blank got=%b want=0", bn); end
    total++; if (hs !== 1'b1 || vs !== 1'b1) begin bad++; $display("FAIL reset_sync got=%b%b want=11", hs, vs); end
    total++; if (fs !== 1'b0 || fc !== 16'd0) begin bad++; $display("FAIL reset_frame got=%b/%0d want=0/0", fs, fc); end
    total++; if ({vr, vg, vb} !== 24'd0) begin bad++; $display("FAIL reset_rgb got=%h want=0", {vr, vg, vb}); end
    rst = 0;
    #1;
    total++; if (req !== 1'b1 || x !== 10'd0 || y !== 10'd0) begin bad++; $display("FAIL release_req got=%b(%0d,%0d) want=1(0,0)", req, x, y); end
    k = 0;
    px = x[7:0];
    py = y[7:0];
  endtask
  task automatic test_lines();
    int rq[3];
    int xy_err = 0, pix_err = 0, vs_err = 0, fs_cnt = 0, fs_pos = -1, bn_rise = -1;
    int hs_fall1 = -1, hs_fall2 = -1, hs_rise1 = -1, eh, ev, ka;
    logic pbn = 0, phs = 1, eact;
    rq = '{0, 0, 0};
    for (int c = 0; c < 2400; c++) begin
      eh = k % 800;
      ev = k / 800;
      if (req === 1'b1) rq[ev]++;
      if (req !== (eh < 640)) xy_err++;
      else if (req ? (x !== 10'(eh) || y !== 10'(ev)) : (x !== 10'd0 || y !== 10'd0)) xy_err++;
      ka = k - 2;
      eact = ka >= 0 && ka % 800 < 640;
      if (bn !== eact) pix_err++;
      else if (eact ? (vr !== 8'(ka % 800) || vg !== 8'(ka / 800) || vb !== 8'hA5) : ({vr, vg, vb} !== 24'd0)) pix_err++;
      if (vs !== 1'b1) vs_err++;
      if (fs === 1'b1) begin fs_cnt++; fs_pos = k; end
      if (bn === 1'b1 && !pbn && bn_rise < 0) bn_rise = k;
      if (hs === 1'b0 && phs) begin
        if (hs_fall1 < 0) hs_fall1 = k;
        else if (hs_fall2 < 0) hs_fall2 = k;
      end
      if (hs === 1'b1 && !phs && hs_rise1 < 0) hs_rise1 = k;
      pbn = bn;
      phs = hs;
      step();
    end
    for (int l = 0; l < 3; l++) begin
      total++; if (rq[l] != 640) begin bad++; $display("FAIL req_per_line line=%0d got=%0d want=640", l, rq[l]); end
    end
    total++; if (xy_err != 0) begin bad++; $display("FAIL req_xy errors got=%0d want=0", xy_err); end
    total++; if (pix_err != 0) begin bad++; $display("FAIL pixel_data errors got=%0d want=0", pix_err); end
    total++; if (vs_err != 0) begin bad++; $display("FAIL vsync_idle errors got=%0d want=0", vs_err); end
    total++; if (fs_cnt != 1 || fs_pos != 2) begin bad++; $display("FAIL frame_start got=%0d@%0d want=1@2", fs_cnt, fs_pos); end
    total++; if (bn_rise != 2) begin bad++; $display("FAIL blank_rise got=%0d want=2", bn_rise); end
    total++; if (hs_fall1 != 658) begin bad++; $display("FAIL hsync_fall got=%0d want=658", hs_fall1); end
    total++; if (hs_fall1 - bn_rise != 656) begin bad++; $display("FAIL hsync_offset got=%0d want=656", hs_fall1 - bn_rise); end
    total++; if (hs_rise1 - hs_fall1 != 96) begin bad++; $display("FAIL hsync_width got=%0d want=96", hs_rise1 - hs_fall1); end
    total++; if (hs_fall2 - hs_fall1 != 800) begin bad++; $display("FAIL hsync_period got=%0d want=800", hs_fall2 - hs_fall1); end
  endtask
  task automatic test_mid_reset();
    repeat (3100 - k) step();
    total++; if (hs !== 1'b0) begin bad++; $display("FAIL pre_reset_hsync got=%b want=0", hs); end
    rst = 1;
    step();
    total++; if (req !== 1'b0 || bn !== 1'b0 || fs !== 1'b0) begin bad++; $display("FAIL mid_reset_ctl got=%b%b%b want=000", req, bn, fs); end
    total++; if (hs !== 1'b1 || vs !== 1'b1) begin bad++; $display("FAIL mid_reset_sync got=%b%b want=11", hs, vs); end
    total++; if ({vr, vg, vb} !== 24'd0 || fc !== 16'd0) begin bad++; $display("FAIL mid_reset_data got=%h/%0d want=0/0", {vr, vg, vb}, fc); end
    step();
    step();
    total++; if (hs !== 1'b1 || bn !== 1'b0) begin bad++; $display("FAIL mid_reset_hold got=%b%b want=10", hs, bn); end
    rst = 0;
    #1;
    total++; if (req !== 1'b1 || x !== 10'd0 || y !== 10'd0) begin bad++; $display("FAIL restart_req got=%b(%0d,%0d) want=1(0,0)", req, x, y); end
    k = 0;
    px = x[7:0];
    py = y[7:0];
    step();
    step();
    total++; if (fs !== 1'b1 || bn !== 1'b1) begin bad++; $display("FAIL restart_frame got=%b%b want=11", fs, bn); end
    total++; if (vr !== 8'd0 || vg !== 8'd0 || vb !== 8'hA5 || fc !== 16'd0) begin bad++; $display("FAIL restart_pixel got=%h/%0d want=0000a5/0", {vr, vg, vb}, fc); end
  endtask
  task automatic test_small_frame();
    int rq = 0, fs_cnt = 0, fs_a = -1, fs_b = -1, vf1 = -1, vf2 = -1, vr1 = -1, pix_err = 0;
    logic [15:0] fc31 = 16'hDEAD, fc32 = 16'hDEAD;
    logic pvs = 1;
    rst_s = 0;
    #1;
    ks = 0;
    total++; if (s_req !== 1'b1) begin bad++; $display("FAIL small_release got=%b want=1", s_req); end
    for (int c = 0; c < 66; c++) begin
      if (ks < 32 && s_req === 1'b1) rq++;
      if (s_fs === 1'b1) begin
        fs_cnt++;
        if (fs_a < 0) fs_a = ks; else fs_b = ks;
      end
      if (s_vs === 1'b0 && pvs) begin
        if (vf1 < 0) vf1 = ks; else if (vf2 < 0) vf2 = ks;
      end
      if (s_vs === 1'b1 && !pvs && vr1 < 0) vr1 = ks;
      if (s_bn ? ({s_r, s_g, s_b} !== 24'h3C3C3C) : ({s_r, s_g, s_b} !== 24'd0)) pix_err++;
      if (ks == 31) fc31 = s_fc;
      if (ks == 32) fc32 = s_fc;
      pvs = s_vs;
      step();
    end
    total++; if (rq != 8) begin bad++; $display("FAIL small_req_count got=%0d want=8", rq); end
    total++; if (fs_cnt != 2 || fs_a != 2 || fs_b != 34) begin bad++; $display("FAIL small_frame_start got=%0d@%0d,%0d want=2@2,34", fs_cnt, fs_a, fs_b); end
    total++; if (vf1 != 26) begin bad++; $display("FAIL small_vsync_fall got=%0d want=26", vf1); end
    total++; if (vr1 - vf1 != 8) begin bad++; $display("FAIL small_vsync_width got=%0d want=8", vr1 - vf1); end
    total++; if (vf2 - vf1 != 32) begin bad++; $display("FAIL small_vsync_period got=%0d want=32", vf2 - vf1); end
    total++; if (fc31 !== 16'd0 || fc32 !== 16'd1) begin bad++; $display("FAIL small_frame_cnt got=%0d,%0d want=0,1", fc31, fc32); end
    total++; if (pix_err != 0) begin bad++; $display("FAIL small_rgb_mask errors got=%0d want=0", pix_err); end
  endtask
  task automatic test_frame_wrap();
    int fs_cnt = 0, fs_pos = -1;
    logic [15:0] fc95 = 16'hDEAD, fc96 = 16'hDEAD;
    force u_s.r_frame_cnt = 16'hFFFF;
    step();
    release u_s.r_frame_cnt;
    #1;
    total++; if (s_fc !== 16'hFFFF) begin bad++; $display("FAIL wrap_preset got=%h want=ffff", s_fc); end
    while (ks < 101) begin
      if (s_fs === 1'b1) begin fs_cnt++; fs_pos = ks; end
      if (ks == 95) fc95 = s_fc;
      if (ks == 96) fc96 = s_fc;
      step();
    end
    total++; if (fc95 !== 16'hFFFF || fc96 !== 16'd0) begin bad++; $display("FAIL frame_cnt_wrap got=%h,%h want=ffff,0000", fc95, fc96); end
    total++; if (fs_cnt != 1 || fs_pos != 98) begin bad++; $display("FAIL wrap_frame_start got=%0d@%0d want=1@98", fs_cnt, fs_pos); end
  endtask
  task automatic test_small_reset();
    repeat (124 - ks) step();
    total++; if (s_vs !== 1'b0) begin bad++; $display("FAIL small_pre_reset_vsync got=%b want=0", s_vs); end
    rst_s = 1;
    step();
    total++; if (s_vs !== 1'b1 || s_hs !== 1'b1) begin bad++; $display("FAIL small_reset_sync got=%b%b want=11", s_hs, s_vs); end
    total++; if (s_fc !== 16'd0 || s_bn !== 1'b0 || s_req !== 1'b0) begin bad++; $display("FAIL small_reset_state got=%0d/%b/%b want=0/0/0", s_fc, s_bn, s_req); end
  endtask
  initial begin
    test_reset();
    test_lines();
    test_mid_reset();
    test_small_frame();
    test_frame_wrap();
    test_small_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
